text_ber_monitor: RTL and testbench



---
 rtl/text_ber_monitor_pkg.sv | 23 ++
 rtl/text_ber_monitor_if.sv | 12 +
 rtl/text_ref_rom.sv | 25 ++
 rtl/text_ber_monitor.sv | 165 ++++++++++++++++
 tb/tb_text_ber_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/text_ber_monitor_pkg.sv
// Shared definitions for the text link checker: FSM states, character width
// and the reference message used by both the source stage and the monitor.
package text_ber_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CHAR_W  = 8;
   localparam int REF_LEN = 16;
   localparam logic [CHAR_W*REF_LEN-1:0] REF_MSG = "HELLO_WORLD_1234";

   // Character pos of the message; the first character sits in the top byte.
   function automatic logic [CHAR_W-1:0] ref_char(input int unsigned pos);
      int unsigned k;
      k = pos % REF_LEN;
      return REF_MSG[CHAR_W*(REF_LEN-1-k) +: CHAR_W];
   endfunction

endpackage

// File: rtl/text_ber_monitor_if.sv
// Recovered-character stream between the decompressor and the monitor.
interface text_ber_monitor_if;
   import text_ber_monitor_pkg::*;

   logic              in_valid;
   logic [CHAR_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/text_ref_rom.sv
// Reference message ROM with a single registered read port.
module text_ref_rom
   import text_ber_monitor_pkg::*;
#(
   parameter int MSG_LEN = 16,
   parameter int ADDR_W  = 4
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [CHAR_W-1:0] data
);

   logic [CHAR_W-1:0] rom_table [MSG_LEN];

   generate
      for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_rom
         assign rom_table[gi] = ref_char(gi);
      end
   endgenerate

   always_ff @(posedge clk) begin
      data <= rom_table[addr];
   end

endmodule

// File: rtl/text_ber_monitor.sv
// Compares the recovered character stream against the reference message and
// accumulates character/bit error counts over one message run.
module text_ber_monitor
   import text_ber_monitor_pkg::*;
#(
   parameter int MSG_LEN = 16,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   text_ber_monitor_if.slave in_if,
   output logic             busy,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] char_count,
   output logic [CNT_W-1:0] char_err_count,
   output logic [CNT_W-1:0] bit_err_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             first_err_valid
);

   localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   function automatic logic [3:0] popcount8(input logic [CHAR_W-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < CHAR_W; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg;
   logic [TMR_W-1:0]  timer_reg;
   logic              drain_reg;
   logic              ready;
   logic              accept, restart, last_char, timeout_hit;

   logic              s1_valid_reg, s2_valid_reg;
   logic [CHAR_W-1:0] s1_data_reg, ref_q;
   logic [IDX_W-1:0]  s1_idx_reg, s2_idx_reg;
   logic [3:0]        s2_pc_reg;

   assign accept      = in_if.in_valid && ready;
   assign restart     = start && (state_reg == IDLE || state_reg == DONE);
   assign last_char   = accept && (idx_reg == IDX_W'(MSG_LEN - 1));
   assign timeout_hit = (state_reg == RUN) && !accept && (timer_reg == TMR_W'(TIMEOUT - 1));
   assign in_if.in_ready = ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (restart) state_next = RUN;
         RUN:     if (last_char || timeout_hit) state_next = DRAIN;
         DRAIN:   if (drain_reg) state_next = DONE;
         DONE:    state_next = restart ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_reg)
         RUN:     begin ready = 1'b1; busy = 1'b1; end
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Run control: character index, idle timer, drain length, timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_reg   <= '0;
         timer_reg <= '0;
         drain_reg <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         drain_reg <= (state_reg == DRAIN) && !drain_reg;
         if (restart) begin
            idx_reg   <= '0;
            timer_reg <= '0;
            timed_out <= 1'b0;
         end else if (state_reg == RUN) begin
            if (accept) begin
               idx_reg   <= idx_reg + 1'b1;
               timer_reg <= '0;
            end else begin
               timer_reg <= timer_reg + 1'b1;
            end
            if (timeout_hit) timed_out <= 1'b1;
         end
      end
   end

   text_ref_rom #(
      .MSG_LEN (MSG_LEN),
      .ADDR_W  (IDX_W)
   ) u_rom (
      .clk  (clk),
      .addr (idx_reg),
      .data (ref_q)
   );

   // Stage 1 aligns the captured character with the ROM word; stage 2 holds its error weight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s1_idx_reg   <= '0;
         s2_valid_reg <= 1'b0;
         s2_pc_reg    <= '0;
         s2_idx_reg   <= '0;
      end else begin
         s1_valid_reg <= accept;
         s1_data_reg  <= in_if.in_data;
         s1_idx_reg   <= idx_reg;
         s2_valid_reg <= s1_valid_reg;
         s2_pc_reg    <= popcount8(s1_data_reg ^ ref_q);
         s2_idx_reg   <= s1_idx_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         char_count      <= '0;
         char_err_count  <= '0;
         bit_err_count   <= '0;
         first_err_idx   <= '0;
         first_err_valid <= 1'b0;
      end else if (restart) begin
         char_count      <= '0;
         char_err_count  <= '0;
         bit_err_count   <= '0;
         first_err_idx   <= '0;
         first_err_valid <= 1'b0;
      end else if (s2_valid_reg) begin
         char_count <= sat_add(char_count, 4'd1);
         if (s2_pc_reg != 4'd0) begin
            char_err_count <= sat_add(char_err_count, 4'd1);
            bit_err_count  <= sat_add(bit_err_count, s2_pc_reg);
            if (!first_err_valid) begin
               first_err_idx   <= CNT_W'(s2_idx_reg);
               first_err_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_text_ber_monitor.sv
// Self-checking bench for text_ber_monitor: directed and randomized message runs
// compared against a behavioural error-count model.
module tb_text_ber_monitor;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        busy, done, timed_out, first_err_valid;
   logic [15:0] char_count, char_err_count, bit_err_count, first_err_idx;

   always #5 clk = ~clk;

   text_ber_monitor_if bus();

   text_ber_monitor #(
      .MSG_LEN (16),
      .CNT_W   (16),
      .TIMEOUT (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .in_if           (bus),
      .busy            (busy),
      .done            (done),
      .timed_out       (timed_out),
      .char_count      (char_count),
      .char_err_count  (char_err_count),
      .bit_err_count   (bit_err_count),
      .first_err_idx   (first_err_idx),
      .first_err_valid (first_err_valid)
   );

   string      ref_msg = "HELLO_WORLD_1234";
   logic [7:0] sent [16];
   int         checks = 0, failures = 0;
   int         cyc = 0, done_count = 0, last_acc = 0;
   int         e_char, e_cerr, e_berr, e_fidx;
   logic       e_fv;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] ref_byte(input int i);
      return ref_msg[i];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected results from the sent characters and the reference text.
   task automatic model(input int n);
      logic [7:0] d;
      e_char = n; e_cerr = 0; e_berr = 0; e_fidx = 0; e_fv = 1'b0;
      for (int i = 0; i < n; i++) begin
         d = sent[i] ^ ref_byte(i);
         if (d != 8'h00) begin
            e_cerr++;
            e_berr += $countones(d);
            if (!e_fv) begin e_fv = 1'b1; e_fidx = i; end
         end
      end
   endtask

   task automatic pulse_start(output int s);
      @(posedge clk); #2;
      start = 1'b1;
      @(negedge clk); s = cyc;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic idle_gap(input int g);
      bus.in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #2; end
   endtask

   task automatic push(input logic [7:0] d);
      logic seen;
      seen = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin seen = 1'b1; last_acc = cyc + 1; break; end
      end
      chk("push.in_ready", 32'(seen), 32'd1);
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int d);
      logic got;
      got = 1'b0; d = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin got = 1'b1; d = cyc; break; end
      end
      chk({tag, ".done_seen"}, 32'(got), 32'd1);
   endtask

   task automatic check_counts(input string tag, input logic exp_to);
      chk({tag, ".char_count"},      32'(char_count),      32'(e_char));
      chk({tag, ".char_err_count"},  32'(char_err_count),  32'(e_cerr));
      chk({tag, ".bit_err_count"},   32'(bit_err_count),   32'(e_berr));
      chk({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(e_fv));
      if (e_fv) chk({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(e_fidx));
      chk({tag, ".timed_out"},       32'(timed_out),       32'(exp_to));
   endtask

   task automatic run_msg(input string tag, input int n, input int max_gap, input bit chk_lat,
                          input bit exp_to, input bit hold_start, output int d);
      int s;
      pulse_start(s);
      for (int i = 0; i < n; i++) begin
         if (max_gap > 0) idle_gap(int'($urandom_range(max_gap, 0)));
         push(sent[i]);
      end
      model(n);
      wait_done(tag, d);
      if (chk_lat) chk({tag, ".start_to_done"}, 32'(d - s), 32'd19);
      if (exp_to)  chk({tag, ".accept_to_done"}, 32'(d - last_acc), 32'd10);
      check_counts(tag, exp_to);
      chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      if (hold_start) begin
         start = 1'b1;
      end else begin
         @(negedge clk);
         chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
      end
      $display("run %s: chars=%0d cerr=%0d berr=%0d first=%0d/%0d to=%0d done_cyc=%0d",
               tag, char_count, char_err_count, bit_err_count, first_err_valid, first_err_idx, timed_out, d);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".busy"},            32'(busy),            32'd0);
      chk({tag, ".done"},            32'(done),            32'd0);
      chk({tag, ".in_ready"},        32'(bus.in_ready),    32'd0);
      chk({tag, ".timed_out"},       32'(timed_out),       32'd0);
      chk({tag, ".char_count"},      32'(char_count),      32'd0);
      chk({tag, ".char_err_count"},  32'(char_err_count),  32'd0);
      chk({tag, ".bit_err_count"},   32'(bit_err_count),   32'd0);
      chk({tag, ".first_err_idx"},   32'(first_err_idx),   32'd0);
      chk({tag, ".first_err_valid"}, 32'(first_err_valid), 32'd0);
   endtask

   initial begin
      int d, d2, dc;
      reset = 1'b1; start = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = 8'h00;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("idle");

      for (int i = 0; i < 16; i++) sent[i] = ref_byte(i);
      run_msg("clean", 16, 0, 1'b1, 1'b0, 1'b0, d);

      for (int i = 0; i < 16; i++) sent[i] = ref_byte(i);
      sent[3]  = sent[3]  ^ 8'h01;
      sent[10] = sent[10] ^ 8'h01;
      run_msg("single_bit", 16, 0, 1'b1, 1'b0, 1'b0, d);

      for (int i = 0; i < 16; i++) sent[i] = ref_byte(i);
      sent[0] = ~ref_byte(0);
      run_msg("full_byte", 16, 0, 1'b1, 1'b0, 1'b0, d);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++)
            sent[i] = ref_byte(i) ^ (($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00);
         run_msg($sformatf("random%0d", r), 16, 2, 1'b0, 1'b0, 1'b0, d);
      end

      for (int i = 0; i < 16; i++)
         sent[i] = ref_byte(i) ^ (($urandom_range(1, 0) == 0) ? 8'($urandom) : 8'h00);
      run_msg("timeout", 5, 3, 1'b0, 1'b1, 1'b0, d);

      // Abort a run with errors already counted.
      for (int i = 0; i < 16; i++) sent[i] = ~ref_byte(i);
      pulse_start(d);
      for (int i = 0; i < 7; i++) push(sent[i]);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      @(posedge clk); #2;
      reset = 1'b0;
      dc = done_count;
      repeat (30) @(posedge clk);
      #2;
      chk("mid_reset.no_done", 32'(done_count), 32'(dc));
      for (int i = 0; i < 16; i++) sent[i] = ref_byte(i);
      run_msg("post_reset", 16, 0, 1'b1, 1'b0, 1'b0, d);

      // Restart in the done cycle, then a stray start during RUN.
      for (int i = 0; i < 16; i++) sent[i] = ref_byte(i) ^ ((i % 4 == 1) ? 8'h81 : 8'h00);
      run_msg("restart_pre", 16, 0, 1'b1, 1'b0, 1'b1, d);
      for (int i = 0; i < 16; i++) sent[i] = ref_byte(i);
      bus.in_valid = 1'b1;
      bus.in_data  = sent[0];
      @(posedge clk); #2;
      start = 1'b0;
      @(negedge clk);
      chk("restart.char_count_cleared", 32'(char_count), 32'd0);
      chk("restart.err_cleared",        32'(char_err_count), 32'd0);
      chk("restart.busy",               32'(busy), 32'd1);
      @(posedge clk); #2;
      for (int i = 1; i < 16; i++) begin
         if (i == 5) start = 1'b1;
         push(sent[i]);
         start = 1'b0;
      end
      model(16);
      wait_done("restart", d2);
      chk("restart.start_to_done", 32'(d2 - d), 32'd19);
      check_counts("restart", 1'b0);
      $display("run restart: chars=%0d cerr=%0d berr=%0d done_cyc=%0d",
               char_count, char_err_count, bit_err_count, d2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
